// File: rtl/sram_client_mux_pkg.sv
// rtl/sram_client_mux_pkg.sv - shared widths, state encoding and helpers for the SRAM client mux
package sram_client_mux_pkg;

  localparam int N_CLIENTS = 3;
  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DATA = 2'd3
  } mux_state_t;

  // Next client index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/sram_client_mux_rr_pick3.sv
// rtl/sram_client_mux_rr_pick3.sv - combinational 3-way round-robin / fixed-priority picker
module rr_pick3
  import sram_client_mux_pkg::*;
(
  input  logic [2:0] want,
  input  logic [1:0] last,
  input  logic       fixed,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  // Fixed mode: lowest index wins. Rotating mode: search starts one past the last grant.
  always_comb begin
    any    = |want;
    idx    = 2'd0;
    first  = next_idx(last);
    second = next_idx(first);
    third  = next_idx(second);
    if (fixed) begin
      if (want[0])      idx = 2'd0;
      else if (want[1]) idx = 2'd1;
      else if (want[2]) idx = 2'd2;
    end else begin
      if (want[first])       idx = first;
      else if (want[second]) idx = second;
      else if (want[third])  idx = third;
    end
  end

endmodule

// File: rtl/sram_client_mux.sv
// rtl/sram_client_mux.sv - shares one toggle-handshake SRAM arbiter port among three clients
module sram_client_mux
  import sram_client_mux_pkg::*;
#(
  parameter int RD_LAT     = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                          clk200,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          cl_req,
  output logic [N_CLIENTS-1:0]          cl_ack,
  input  logic [N_CLIENTS-1:0]          cl_read,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cl_address,
  input  logic [N_CLIENTS-1:0]          cl_lb,
  input  logic [N_CLIENTS-1:0]          cl_ub,
  input  logic [N_CLIENTS*DATA_W-1:0]   cl_wdata,
  output logic [N_CLIENTS*DATA_W-1:0]   cl_rdata,
  output logic                          dn_req,
  input  logic                          dn_ack,
  output logic                          dn_read,
  output logic [ADDR_W-1:0]             dn_address,
  output logic                          dn_lb,
  output logic                          dn_ub,
  output logic [DATA_W-1:0]             dn_wdata,
  input  logic [DATA_W-1:0]             dn_rdata
);

  // Counter starts at RD_LAT-1 so the capture edge lands RD_LAT edges after ack is seen.
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  mux_state_t state;
  logic [1:0] last_grant;
  logic [1:0] gnt;
  logic [3:0] lat_cnt;

  logic [2:0] want;
  logic       pick_any;
  logic [1:0] pick_idx;

  assign want = cl_req ^ cl_ack;

  rr_pick3 u_pick (
    .want  (want),
    .last  (last_grant),
    .fixed (FIXED_PRIO),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // Single controller: align to the arbiter, grant, wait for ack, wait out read latency, return ack.
  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      state      <= ST_SYNC;
      last_grant <= 2'd2;
      gnt        <= 2'd0;
      lat_cnt    <= 4'd0;
      cl_ack     <= '0;
      cl_rdata   <= '0;
      dn_req     <= 1'b0;
      dn_read    <= 1'b1;
      dn_address <= '0;
      dn_lb      <= 1'b0;
      dn_ub      <= 1'b0;
      dn_wdata   <= '0;
    end else begin
      case (state)
        ST_SYNC: begin
          dn_req <= dn_ack;
          state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (pick_any) begin
            gnt        <= pick_idx;
            if (!FIXED_PRIO) last_grant <= pick_idx;
            dn_read    <= cl_read[pick_idx];
            dn_address <= cl_address[pick_idx*ADDR_W +: ADDR_W];
            dn_lb      <= cl_lb[pick_idx];
            dn_ub      <= cl_ub[pick_idx];
            dn_wdata   <= cl_wdata[pick_idx*DATA_W +: DATA_W];
            dn_req     <= ~dn_req;
            state      <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (dn_ack == dn_req) begin
            if (dn_read) begin
              lat_cnt <= LAT_INIT;
              state   <= ST_WAIT_DATA;
            end else begin
              cl_ack[gnt] <= ~cl_ack[gnt];
              state       <= ST_IDLE;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (lat_cnt == 4'd0) begin
            cl_rdata[gnt*DATA_W +: DATA_W] <= dn_rdata;
            cl_ack[gnt]                    <= ~cl_ack[gnt];
            state                          <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
